// File: rtl/data_mem_bridge_pkg.sv
// Shared types and constants for the datapath-to-Avalon data memory bridge.
package data_mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/data_mem_bridge_lane_steer.sv
// Combinational lane steering: byte enables, replicated store data and alignment check.
module lane_steer
  import data_mem_bridge_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wd_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  output logic        misaligned_o
);

  always_comb begin
    be_o         = 4'b0000;
    wd_o         = 32'h0;
    misaligned_o = 1'b0;
    case (size_i)
      SIZE_BYTE: begin
        be_o = 4'b0001 << addr_lo_i;
        wd_o = {4{wd_i[7:0]}};
      end
      SIZE_HALF: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wd_o         = {2{wd_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      // SIZE_WORD and the reserved encoding 2'b11 both mean a full word.
      default: begin
        be_o         = 4'b1111;
        wd_o         = wd_i;
        misaligned_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// Stalls the single-cycle datapath while one load/store runs on an Avalon-MM bus.
// Optional waitrequest timeout is enabled with DATA_MEM_BRIDGE_TIMEOUT_EN.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_stall,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        misaligned,
  output logic        bus_error,
  output state_e      dbg_state
);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        read_q;
  logic        write_q;
  logic        misaligned_q;

  logic [3:0]  steer_be;
  logic [31:0] steer_wd;
  logic        steer_mis;
  logic        req;

  lane_steer u_lane_steer (
    .size_i       (cpu_size),
    .addr_lo_i    (cpu_address[1:0]),
    .wd_i         (cpu_writedata),
    .be_o         (steer_be),
    .wd_o         (steer_wd),
    .misaligned_o (steer_mis)
  );

  assign req = cpu_read | cpu_write;

`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             bus_error_q;
  logic             timeout_hit;

  // The current waitrequest cycle is the one that brings the count to the limit.
  assign timeout_hit = avm_waitrequest && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_error   = bus_error_q;
`else
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= 32'h0;
      be_q         <= 4'b0000;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      misaligned_q <= 1'b0;
`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
      wait_cnt_q   <= '0;
      bus_error_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= {cpu_address[31:2], 2'b00};
            be_q    <= steer_be;
            wdata_q <= steer_wd;
`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
            if (steer_mis) begin
              misaligned_q <= 1'b1;
              rdata_q      <= 32'h0;
              state_q      <= ST_DONE;
            end else if (cpu_write) begin
              write_q <= 1'b1;
              state_q <= ST_WRITE;
            end else begin
              read_q  <= 1'b1;
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (!avm_waitrequest) begin
            rdata_q <= avm_readdata;
            read_q  <= 1'b0;
            state_q <= ST_DONE;
          end
`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
          else if (timeout_hit) begin
            rdata_q     <= 32'h0;
            read_q      <= 1'b0;
            bus_error_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        ST_WRITE: begin
          if (!avm_waitrequest) begin
            write_q <= 1'b0;
            state_q <= ST_DONE;
          end
`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
          else if (timeout_hit) begin
            rdata_q     <= 32'h0;
            write_q     <= 1'b0;
            bus_error_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Combinational so the datapath cannot commit in the cycle the request is first seen.
  assign cpu_stall = ((state_q == ST_IDLE) && req) ||
                     (state_q == ST_READ) || (state_q == ST_WRITE);

  assign cpu_readdata   = rdata_q;
  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = wdata_q;
  assign misaligned     = misaligned_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Randomized bench for data_mem_bridge with a transaction-level reference model.
module tb_data_mem_bridge;
  import data_mem_bridge_pkg::*;

`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
  localparam int TMO_LIMIT = 8;
`else
  localparam int TMO_LIMIT = 1 << 30;
`endif

  logic        clk;
  logic        reset;
  logic        cpu_read;
  logic        cpu_write;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_address;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_stall;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        misaligned;
  logic        bus_error;
  state_e      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];
  logic [31:0] exp_rd;
  bit          exp_mis;
  bit          exp_err;

  data_mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_read        (cpu_read),
    .cpu_write       (cpu_write),
    .cpu_size        (cpu_size),
    .cpu_address     (cpu_address),
    .cpu_writedata   (cpu_writedata),
    .cpu_readdata    (cpu_readdata),
    .cpu_stall       (cpu_stall),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_byteenable  (avm_byteenable),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .misaligned      (misaligned),
    .bus_error       (bus_error),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] slv_word(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
  endfunction

  // ---------------- driver + model ----------------
  task automatic do_access(input bit wr, input bit rd, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd, input int waits);
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_addr, w;
    bit          mis, tmo;
    int          bus_cyc, total, wl;
    bit          bus_now;

    // Reference: what a correct bridge must do for this instruction.
    e_addr = addr & 32'hFFFF_FFFC;
    case (sz)
      2'd0: begin
        e_be = 4'(1 << addr[1:0]);
        e_wd = {24'h0, wd[7:0]} * 32'h0101_0101;
        mis  = 1'b0;
      end
      2'd1: begin
        e_be = (addr[1:0] >= 2) ? 4'hC : 4'h3;
        e_wd = {16'h0, wd[15:0]} * 32'h0001_0001;
        mis  = (addr % 2) != 0;
      end
      default: begin
        e_be = 4'hF;
        e_wd = wd;
        mis  = (addr % 4) != 0;
      end
    endcase
    tmo     = !mis && (waits >= TMO_LIMIT);
    bus_cyc = mis ? 0 : (tmo ? TMO_LIMIT : waits + 1);
    total   = bus_cyc + 2;
    if (mis) begin
      exp_mis = 1'b1;
      exp_rd  = 32'h0;
    end else if (tmo) begin
      exp_err = 1'b1;
      exp_rd  = 32'h0;
    end else if (wr) begin
      w = ref_word(e_addr);
      for (int b = 0; b < 4; b++)
        if (e_be[b]) w[8*b +: 8] = e_wd[8*b +: 8];
      ref_mem[e_addr] = w;
    end else begin
      exp_rd = ref_word(e_addr);
    end
    exp_q.push_back(exp_rd);

    @(negedge clk);
    cpu_write     = wr;
    cpu_read      = rd;
    cpu_size      = sz;
    cpu_address   = addr;
    cpu_writedata = wd;
    wl = waits;
    for (int k = 0; k < total; k++) begin
      avm_waitrequest = (wl > 0);
      avm_readdata    = avm_waitrequest ? $urandom : slv_word(avm_address);
      #1;
      bus_now = (k >= 1) && (k <= bus_cyc);
      check_val("stall", 32'(cpu_stall), 32'(k < total - 1));
      check_val("avm_read", 32'(avm_read), 32'(bus_now && !wr));
      check_val("avm_write", 32'(avm_write), 32'(bus_now && wr));
      if (bus_now) begin
        check_val("avm_address", avm_address, e_addr);
        check_val("avm_byteenable", 32'(avm_byteenable), 32'(e_be));
        check_val("avm_writedata", avm_writedata, e_wd);
        if (avm_write && !avm_waitrequest) begin
          w = slv_word(avm_address);
          for (int b = 0; b < 4; b++)
            if (avm_byteenable[b]) w[8*b +: 8] = avm_writedata[8*b +: 8];
          slv_mem[avm_address] = w;
        end
        if (avm_waitrequest) wl--;
      end
      if (k == total - 1) begin
        check_val("done_state", 32'(dbg_state), 32'(ST_DONE));
        check_val("cpu_readdata", cpu_readdata, exp_q.pop_front());
        check_val("misaligned", 32'(misaligned), 32'(exp_mis));
        check_val("bus_error", 32'(bus_error), 32'(exp_err));
      end
      @(negedge clk);
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    avm_waitrequest = 1'b0;
    #1;
    check_val("idle_stall", 32'(cpu_stall), 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset           = 1'b0;
    cpu_read        = 1'b0;
    cpu_write       = 1'b0;
    cpu_size        = 2'b10;
    cpu_address     = 32'h0;
    cpu_writedata   = 32'h0;
    avm_readdata    = 32'h0;
    avm_waitrequest = 1'b0;
    exp_rd  = 32'h0;
    exp_mis = 1'b0;
    exp_err = 1'b0;

    #1;
    check_val("rst_stall", 32'(cpu_stall), 32'h0);
    check_val("rst_strobes", {30'h0, avm_read, avm_write}, 32'h0);
    check_val("rst_address", avm_address, 32'h0);
    check_val("rst_be", 32'(avm_byteenable), 32'h0);
    check_val("rst_wdata", avm_writedata, 32'h0);
    check_val("rst_rdata", cpu_readdata, 32'h0);
    check_val("rst_flags", {30'h0, misaligned, bus_error}, 32'h0);
    check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_val("nonmem_stall", 32'(cpu_stall), 32'h0);

    // Directed cases from the bring-up plan.
    ref_mem[32'h100] = 32'hCAFE_BABE;
    slv_mem[32'h100] = 32'hCAFE_BABE;
    do_access(1'b0, 1'b1, SIZE_WORD, 32'h100, 32'h0, 0);
    do_access(1'b1, 1'b0, SIZE_BYTE, 32'h203, 32'h0000_00A5, 0);
    do_access(1'b1, 1'b0, SIZE_HALF, 32'h202, 32'h1234_BEEF, 1);
    do_access(1'b0, 1'b1, SIZE_WORD, 32'h200, 32'h0, 0);
    do_access(1'b0, 1'b1, SIZE_WORD, 32'h40, 32'h0, 4);
    do_access(1'b0, 1'b1, SIZE_HALF, 32'h101, 32'h0, 0);
    do_access(1'b1, 1'b1, 2'b11, 32'h44, 32'h8765_4321, 2);
    do_access(1'b0, 1'b1, SIZE_WORD, 32'h44, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      bit          wr, rd;
      logic [1:0]  sz, lo;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      sz = 2'($urandom_range(0, 3));
      lo = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SIZE_HALF) lo[0] = 1'b0;
        else if (sz != SIZE_BYTE) lo = 2'b00;
      end
      a = 32'($urandom_range(0, 31)) * 4 + 32'(lo);
      do_access(wr, rd, sz, a, $urandom, $urandom_range(0, 3));
    end

    // Reset during the second waitrequest cycle of a word store.
    @(negedge clk);
    cpu_write       = 1'b1;
    cpu_read        = 1'b0;
    cpu_size        = SIZE_WORD;
    cpu_address     = 32'h300;
    cpu_writedata   = 32'hDEAD_0001;
    avm_waitrequest = 1'b1;
    @(negedge clk);
    #1 check_val("mid_write_strobe1", 32'(avm_write), 32'h1);
    @(negedge clk);
    #1 check_val("mid_write_strobe2", 32'(avm_write), 32'h1);
    #1 reset = 1'b0;
    #1;
    check_val("arst_write_drop", 32'(avm_write), 32'h0);
    check_val("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_val("arst_flags", {30'h0, misaligned, bus_error}, 32'h0);
    check_val("arst_rdata", cpu_readdata, 32'h0);
    cpu_write = 1'b0;
    avm_waitrequest = 1'b0;
    exp_rd  = 32'h0;
    exp_mis = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 check_val("post_rst_stall", 32'(cpu_stall), 32'h0);
    @(negedge clk);
    #1 check_val("post_rst_write", 32'(avm_write), 32'h0);
    do_access(1'b0, 1'b1, SIZE_WORD, 32'h300, 32'h0, 1);

`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
    do_access(1'b0, 1'b1, SIZE_WORD, 32'h48, 32'h0, 40);
    do_access(1'b1, 1'b0, SIZE_WORD, 32'h4C, 32'h1111_2222, 40);
    do_access(1'b0, 1'b1, SIZE_WORD, 32'h4C, 32'h0, 7);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_bridge.md
# data_mem_bridge

Bridge between the single-cycle MIPS datapath's data port and an Avalon-MM style data memory with `waitrequest`. Each load or store becomes one bus transaction with byte enables and lane-replicated write data. The bridge stalls the datapath by driving `cpu_stall`, which is inverted to form the datapath `clk_enable`, until the access completes. It sits directly downstream of the datapath's `data_address`/`data_writedata`/`data_readdata` port.

## Interface
- `TIMEOUT_CYCLES`, 255: waitrequest cycles tolerated before abort (used only with `DATA_MEM_BRIDGE_TIMEOUT_EN`).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_read` in 1: load request from control.
- `cpu_write` in 1: store request from control.
- `cpu_size` in 2: access size; 00 byte, 01 half, 10 word, 11 treated as word.
- `cpu_address` in 32: byte address (ALU result).
- `cpu_writedata` in 32: store data, LSB-aligned (rt value).
- `cpu_readdata` out 32: raw memory word, in memory lane positions. Lane extraction is the load selector's job.
- `cpu_stall` out 1: datapath must not commit this cycle.
- `avm_address` out 32: word address, `cpu_address` with [1:0] forced to 00.
- `avm_read` out 1: bus read strobe.
- `avm_write` out 1: bus write strobe.
- `avm_byteenable` out 4: active byte lanes.
- `avm_writedata` out 32: lane-replicated store data.
- `avm_readdata` in 32: bus read data.
- `avm_waitrequest` in 1: slave not ready.
- `misaligned` out 1: sticky, set on a misaligned request.
- `bus_error` out 1: sticky, set on timeout.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE with `cpu_write` goes to WRITE. IDLE with `cpu_read` only goes to READ. `cpu_write` wins if both are high; the read is ignored.
- IDLE with a misaligned request goes to DONE with no bus access, sets `misaligned`, and loads 0 into the read-data register. Misaligned means half with addr[0]=1, or word with addr[1:0]≠00.
- READ: `avm_read`=1. If `avm_waitrequest`=0, capture `avm_readdata` into the read-data register and go to DONE.
- WRITE: `avm_write`=1. If `avm_waitrequest`=0, go to DONE.
- DONE: go to IDLE unconditionally. The datapath commits at the end of DONE. The request seen in the following IDLE belongs to the next instruction.
- `cpu_stall` = (state==IDLE & (`cpu_read`|`cpu_write`)) | state==READ | state==WRITE. It is combinational, so the datapath never commits in the detect cycle.
- Address, byte enables and write data are registered on IDLE exit and held stable for the whole transaction.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Write data:
  - byte: {4{wd[7:0]}}
  - half: {2{wd[15:0]}}
  - word: wd
- `cpu_readdata` is driven from the read-data register. It is valid in DONE and holds until the next capture.

## Timing
- Reset values: state IDLE; `avm_read`=0, `avm_write`=0, `avm_byteenable`=0, `avm_address`=0, `avm_writedata`=0; read-data register 0; `misaligned`=0, `bus_error`=0.
- `cpu_stall` follows its combinational equation during reset: 0 while state is IDLE with no request.
- Zero-wait access takes 3 cycles: detect (IDLE), bus (READ/WRITE), commit (DONE). Each waitrequest cycle adds 1.
- Non-memory instructions are never stalled.
- Strobes are asserted for exactly the cycles spent in READ/WRITE.
- Reset asserted mid-transaction:
  - strobes drop asynchronously and state returns to IDLE;
  - no partial capture occurs;
  - the sticky flags clear.
- `misaligned` and `bus_error` clear only on reset.

## Configuration
- `DATA_MEM_BRIDGE_TIMEOUT_EN` defined:
  - A counter increments each READ/WRITE cycle with `avm_waitrequest`=1 and clears on entering READ/WRITE.
  - When the count reaches `TIMEOUT_CYCLES`, the bridge drops the strobe, goes to DONE, loads read data 0 and sets `bus_error`.
- Not defined: the bridge waits indefinitely, `bus_error` is tied 0, and there is no counter logic.

## Structure
- Package `data_mem_bridge_pkg` holds:
  - the state enum;
  - size encodings `SIZE_BYTE`/`SIZE_HALF`/`SIZE_WORD`;
  - the default timeout constant.
- Sub-module `lane_steer` is combinational: (size, addr[1:0], wd) → (byteenable, replicated writedata, misaligned).

## Test plan
- Word load at 0x100, waitrequest low, memory word 0xCAFEBABE:
  - `avm_read` high 1 cycle with address 0x100 and byteenable 1111;
  - `cpu_readdata`=0xCAFEBABE in DONE;
  - `cpu_stall` high exactly 2 cycles.
- Byte store 0x000000A5 at 0x203:
  - `avm_address`=0x200, byteenable 1000, writedata 0xA5A5A5A5;
  - half store at 0x202 → byteenable 1100.
- Word load at 0x40 with waitrequest high 4 cycles:
  - `avm_read` held 5 cycles with stable address;
  - capture only on the waitrequest-low cycle;
  - stall length 6.
- Half load at 0x101:
  - no bus strobe;
  - `misaligned`=1 until reset, `cpu_readdata`=0, stall 1 cycle.
- Reset pulled low during the 2nd waitrequest cycle of a write:
  - `avm_write` falls before the next edge and state is IDLE;
  - after release with no request, `cpu_stall`=0.
- With `DATA_MEM_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, waitrequest stuck high:
  - the strobe drops after 8 cycles;
  - `bus_error`=1 and `cpu_readdata`=0;
  - the datapath resumes.
